spi_flash_responder: RTL and testbench



---
 rtl/flash_spi_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 36 +++
 rtl/spi_flash_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_spi_pkg.sv
// Shared opcodes, address width and FSM state encoding for the SPI flash responder.
package flash_spi_pkg;

  localparam int ADDR_W = 24;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ,
    RDID,
    IGNORE
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with single-cycle rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-3 responder emulating a serial NOR flash: READ (0x03) streams bytes from a
// memory read port with one-byte prefetch, RDID (0x9F) returns a fixed JEDEC ID.
module spi_flash_responder
  import flash_spi_pkg::*;
#(
  parameter logic [ADDR_W-1:0] JEDEC_ID  = 24'hEF4016,
  parameter logic [ADDR_W-1:0] ADDR_MASK = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              underrun
);

  logic w_cs_sync;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_sclk_sync_unused;
  logic w_sclk_rise;
  logic w_sclk_fall;

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .reset  (reset),
    .i_async(spi_cs),
    .o_sync (w_cs_sync),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .reset  (reset),
    .i_async(spi_sclk),
    .o_sync (w_sclk_sync_unused),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // MOSI runs through the same two-flop depth as SCLK so a detected rise sees the
  // data bit that was stable around that rise.
  logic r_mosi_meta;
  logic r_mosi_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= spi_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  state_t            r_state;
  logic [2:0]        r_bit_cnt;
  logic [1:0]        r_byte_idx;
  logic [7:0]        r_rx_shift;
  logic [7:0]        r_tx_shift;
  logic [ADDR_W-1:0] r_addr;
  logic              r_oe;
  logic              r_mem_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_buf;
  logic              r_buf_valid;
  logic              r_stale;
  logic              r_underrun;
  logic [1:0]        r_settle;
  logic              r_armed;

  logic [7:0]        w_rx_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_load;
  logic              w_have;
  logic [7:0]        w_have_byte;
  logic [7:0]        w_id_byte;

  assign w_rx_next   = {r_rx_shift[6:0], r_mosi_sync};
  assign w_addr_next = {r_addr[ADDR_W-2:0], r_mosi_sync};
  assign w_addr_inc  = r_addr + 24'd1;
  // A new byte enters the shifter on the fall that follows each completed group of 8 rises.
  assign w_load      = w_sclk_fall && (r_bit_cnt == 3'd0);
  // A fetch completing in the very cycle of a load is forwarded straight to the shifter.
  assign w_have      = r_buf_valid || (r_mem_valid && mem_ready && !r_stale);
  assign w_have_byte = r_buf_valid ? r_buf : mem_rdata;

  always_comb begin
    w_id_byte = 8'hFF;
    case (r_byte_idx)
      2'd0:    w_id_byte = JEDEC_ID[23:16];
      2'd1:    w_id_byte = JEDEC_ID[15:8];
      2'd2:    w_id_byte = JEDEC_ID[7:0];
      default: w_id_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the fetch buffer and shifters are reset with the control state so a
      // reset mid-transfer leaves nothing stale behind.
      r_state     <= IDLE;
      r_bit_cnt   <= 3'd0;
      r_byte_idx  <= 2'd0;
      r_rx_shift  <= 8'h00;
      r_tx_shift  <= 8'hFF;
      r_addr      <= '0;
      r_oe        <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_buf       <= 8'h00;
      r_buf_valid <= 1'b0;
      r_stale     <= 1'b0;
      r_underrun  <= 1'b0;
      r_settle    <= 2'b00;
      r_armed     <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      r_settle   <= {r_settle[0], 1'b1};
      // Only a CS fall seen after a genuinely high CS starts a transaction.
      if (r_settle[1] && w_cs_sync) r_armed <= 1'b1;

      if (r_state != IDLE && w_cs_rise) begin
        r_state     <= IDLE;
        r_bit_cnt   <= 3'd0;
        r_oe        <= 1'b0;
        r_tx_shift  <= 8'hFF;
        r_mem_valid <= 1'b0;
        r_buf_valid <= 1'b0;
        r_stale     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_cs_fall && r_armed) begin
              r_state   <= CMD;
              r_bit_cnt <= 3'd0;
            end
          end

          CMD: begin
            if (w_sclk_rise) begin
              r_rx_shift <= w_rx_next;
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_idx <= 2'd0;
                case (w_rx_next)
                  CMD_READ: r_state <= ADDR;
                  CMD_RDID: r_state <= RDID;
                  default:  r_state <= IGNORE;
                endcase
              end
            end
          end

          ADDR: begin
            if (w_sclk_rise) begin
              r_addr    <= w_addr_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd2) begin
                  r_state     <= READ;
                  r_mem_valid <= 1'b1;
                  r_mem_addr  <= w_addr_next & ADDR_MASK;
                  r_buf_valid <= 1'b0;
                  r_stale     <= 1'b0;
                end
              end
            end
          end

          // r_addr holds the address of the next byte to enter the shifter.
          READ: begin
            if (w_sclk_rise) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_load) begin
              r_oe        <= 1'b1;
              r_addr      <= w_addr_inc;
              r_buf_valid <= 1'b0;
              if (w_have) begin
                r_tx_shift  <= w_have_byte;
                r_mem_valid <= 1'b1;
                r_mem_addr  <= w_addr_inc & ADDR_MASK;
              end else begin
                r_tx_shift <= 8'hFF;
                r_underrun <= 1'b1;
                if (r_mem_valid && !mem_ready) begin
                  // The late fetch must still complete; its data will be dropped.
                  r_stale <= 1'b1;
                end else begin
                  r_stale     <= 1'b0;
                  r_mem_valid <= 1'b1;
                  r_mem_addr  <= w_addr_inc & ADDR_MASK;
                end
              end
            end else begin
              if (w_sclk_fall) r_tx_shift <= {r_tx_shift[6:0], 1'b1};
              if (r_mem_valid && mem_ready) begin
                if (r_stale) begin
                  r_stale    <= 1'b0;
                  r_mem_addr <= r_addr & ADDR_MASK;
                end else begin
                  r_mem_valid <= 1'b0;
                  r_buf       <= mem_rdata;
                  r_buf_valid <= 1'b1;
                end
              end
            end
          end

          RDID: begin
            if (w_sclk_rise) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_load) begin
              r_oe       <= 1'b1;
              r_tx_shift <= w_id_byte;
              if (r_byte_idx != 2'd3) r_byte_idx <= r_byte_idx + 2'd1;
            end else if (w_sclk_fall) begin
              r_tx_shift <= {r_tx_shift[6:0], 1'b1};
            end
          end

          IGNORE: ;

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // The shifter holds 0xFF whenever the output is disabled, so MISO idles high.
  assign spi_miso    = r_tx_shift[7];
  assign spi_miso_oe = r_oe;
  assign mem_valid   = r_mem_valid;
  assign mem_addr    = r_mem_addr;
  assign busy        = ~w_cs_sync;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench: acts as SPI initiator and as a fixed-latency memory answering addr[7:0]^0x5A.
`timescale 1ns/1ps
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, sclk, mosi;
  logic        sel;
  logic        mem_ready;
  logic [7:0]  mem_rdata;

  logic        cs_a, miso_a, oe_a, mv_a, busy_a, ur_a;
  logic [23:0] ma_a;
  logic        cs_b, miso_b, oe_b, mv_b, busy_b, ur_b;
  logic [23:0] ma_b;

  logic        m_miso, m_oe, m_valid, m_busy, m_ur;
  logic [23:0] m_addr;

  int          errors = 0;
  int          checks = 0;
  int          half = 6;
  int          lat = 2;
  int          busy_cnt = 0;
  int          ur_cnt = 0;
  int          stab_err = 0;
  logic [23:0] lat_addr;
  logic [23:0] log_q[$];

  always #5 clk = ~clk;

  assign cs_a    = sel ? 1'b1 : cs;
  assign cs_b    = sel ? cs : 1'b1;
  assign m_miso  = sel ? miso_b : miso_a;
  assign m_oe    = sel ? oe_b : oe_a;
  assign m_valid = sel ? mv_b : mv_a;
  assign m_addr  = sel ? ma_b : ma_a;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_ur    = sel ? ur_b : ur_a;

  spi_flash_responder u_dut (
    .clk(clk), .reset(reset), .spi_cs(cs_a), .spi_sclk(sclk), .spi_mosi(mosi),
    .spi_miso(miso_a), .spi_miso_oe(oe_a), .mem_valid(mv_a), .mem_ready(mem_ready),
    .mem_addr(ma_a), .mem_rdata(mem_rdata), .busy(busy_a), .underrun(ur_a)
  );

  spi_flash_responder #(.ADDR_MASK(24'h00FFFF)) u_dut_mask (
    .clk(clk), .reset(reset), .spi_cs(cs_b), .spi_sclk(sclk), .spi_mosi(mosi),
    .spi_miso(miso_b), .spi_miso_oe(oe_b), .mem_valid(mv_b), .mem_ready(mem_ready),
    .mem_addr(ma_b), .mem_rdata(mem_rdata), .busy(busy_b), .underrun(ur_b)
  );

  // Memory model: accepts a request when idle, answers after lat clocks with a 1-clk ready.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (busy_cnt > 0) begin
        if (m_valid && m_addr !== lat_addr) stab_err++;
        busy_cnt--;
        if (busy_cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = lat_addr[7:0] ^ 8'h5A;
        end
      end else if (m_valid) begin
        lat_addr = m_addr;
        busy_cnt = lat;
        log_q.push_back(m_addr);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_ur) ur_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin();
    cs = 1'b0;
    wait_clk(half);
  endtask

  task automatic spi_end();
    wait_clk(half);
    cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    rx = 8'h00;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i > 7 - n; i--) begin
      sclk = 1'b0;
      mosi = tx[i];
      wait_clk(half);
      rx[i]  = m_miso;
      oe_all = oe_all & m_oe;
      oe_any = oe_any | m_oe;
      sclk = 1'b1;
      wait_clk(half);
    end
  endtask

  task automatic mem_drain();
    int n = 0;
    while ((busy_cnt != 0 || mem_ready) && n < 300) begin
      wait_clk(1);
      n++;
    end
    checks++;
    if (busy_cnt != 0) begin
      errors++;
      $display("FAIL mem_drain: memory still busy after %0d clk, required idle", n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cs = 1'b1; sclk = 1'b1; mosi = 1'b0; sel = 1'b0;
    wait_clk(3);
    checks++; if (m_miso !== 1'b1)     begin errors++; $display("FAIL rst_miso: got %b exp 1", m_miso); end
    checks++; if (m_oe !== 1'b0)       begin errors++; $display("FAIL rst_oe: got %b exp 0", m_oe); end
    checks++; if (m_valid !== 1'b0)    begin errors++; $display("FAIL rst_mem_valid: got %b exp 0", m_valid); end
    checks++; if (m_addr !== 24'h0)    begin errors++; $display("FAIL rst_mem_addr: got %h exp 000000", m_addr); end
    checks++; if (m_busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b exp 0", m_busy); end
    checks++; if (m_ur !== 1'b0)       begin errors++; $display("FAIL rst_underrun: got %b exp 0", m_ur); end
    reset = 1'b0;
    wait_clk(10);
  endtask

  task automatic test_read();
    logic [7:0] rx;
    logic oe_all, oe_any, oe_hdr;
    logic [7:0] exp_b [4] = '{8'h1F, 8'h1C, 8'h1D, 8'h12};
    sel = 1'b0; half = 4; lat = 2; log_q.delete(); ur_cnt = 0; stab_err = 0;
    spi_begin();
    spi_bits(8'h03, 8, rx, oe_all, oe_any); oe_hdr = oe_any;
    spi_bits(8'h01, 8, rx, oe_all, oe_any); oe_hdr |= oe_any;
    spi_bits(8'h23, 8, rx, oe_all, oe_any); oe_hdr |= oe_any;
    spi_bits(8'h45, 8, rx, oe_all, oe_any); oe_hdr |= oe_any;
    checks++; if (oe_hdr !== 1'b0) begin errors++; $display("FAIL read_hdr_oe: got %b exp 0", oe_hdr); end
    checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b exp 1", m_busy); end
    for (int i = 0; i < 4; i++) begin
      spi_bits(8'h00, 8, rx, oe_all, oe_any);
      checks++; if (rx !== exp_b[i]) begin errors++; $display("FAIL read_byte%0d: got %h exp %h", i, rx, exp_b[i]); end
      checks++; if (oe_all !== 1'b1) begin errors++; $display("FAIL read_oe%0d: got %b exp 1", i, oe_all); end
    end
    spi_end();
    checks++; if (m_oe !== 1'b0)    begin errors++; $display("FAIL read_end_oe: got %b exp 0", m_oe); end
    checks++; if (m_busy !== 1'b0)  begin errors++; $display("FAIL read_end_busy: got %b exp 0", m_busy); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_q.size() <= i || log_q[i] !== 24'h012345 + 24'(i)) begin
        errors++;
        $display("FAIL read_addr%0d: got %h exp %h (requests seen %0d)", i,
                 (log_q.size() > i) ? log_q[i] : 24'hxxxxxx, 24'h012345 + 24'(i), log_q.size());
      end
    end
    checks++; if (ur_cnt !== 0)   begin errors++; $display("FAIL read_underrun: got %0d pulses exp 0", ur_cnt); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL read_addr_stable: got %0d changes exp 0", stab_err); end
    mem_drain();
  endtask

  task automatic test_rdid(input string tag, input int nbytes);
    logic [7:0] rx;
    logic oe_all, oe_any;
    logic [7:0] exp_b [5] = '{8'hEF, 8'h40, 8'h16, 8'hFF, 8'hFF};
    half = 6; log_q.delete();
    spi_begin();
    spi_bits(8'h9F, 8, rx, oe_all, oe_any);
    for (int i = 0; i < nbytes; i++) begin
      spi_bits(8'h00, 8, rx, oe_all, oe_any);
      checks++; if (rx !== exp_b[i]) begin errors++; $display("FAIL %s_byte%0d: got %h exp %h", tag, i, rx, exp_b[i]); end
      checks++; if (oe_all !== 1'b1) begin errors++; $display("FAIL %s_oe%0d: got %b exp 1", tag, i, oe_all); end
    end
    spi_end();
    checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL %s_no_mem: got %0d requests exp 0", tag, log_q.size()); end
  endtask

  task automatic test_addr_mask();
    logic [7:0] rx;
    logic oe_all, oe_any;
    sel = 1'b1; half = 6; lat = 2; log_q.delete();
    spi_begin();
    spi_bits(8'h03, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    spi_bits(8'hFF, 8, rx, oe_all, oe_any);
    spi_bits(8'hFF, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL mask_byte0: got %h exp a5", rx); end
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    checks++; if (rx !== 8'h5A) begin errors++; $display("FAIL mask_byte1: got %h exp 5a", rx); end
    spi_end();
    checks++; if (log_q.size() < 1 || log_q[0] !== 24'h00FFFF) begin errors++; $display("FAIL mask_addr0: exp 00ffff, requests seen %0d", log_q.size()); end
    checks++; if (log_q.size() < 2 || log_q[1] !== 24'h000000) begin errors++; $display("FAIL mask_addr1: got %h exp 000000", (log_q.size() > 1) ? log_q[1] : 24'hxxxxxx); end
    mem_drain();
    sel = 1'b0;
  endtask

  task automatic test_underrun();
    logic [7:0] rx;
    logic oe_all, oe_any;
    sel = 1'b0; half = 6; lat = 40; log_q.delete(); ur_cnt = 0; stab_err = 0;
    spi_begin();
    spi_bits(8'h03, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    spi_bits(8'h10, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL ur_byte0: got %h exp ff", rx); end
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    checks++; if (rx !== 8'h4B) begin errors++; $display("FAIL ur_byte1: got %h exp 4b", rx); end
    spi_end();
    checks++; if (ur_cnt !== 1) begin errors++; $display("FAIL ur_pulses: got %0d exp 1", ur_cnt); end
    checks++; if (log_q.size() < 2 || log_q[1] !== 24'h000011) begin errors++; $display("FAIL ur_next_addr: got %h exp 000011", (log_q.size() > 1) ? log_q[1] : 24'hxxxxxx); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL ur_addr_stable: got %0d changes exp 0", stab_err); end
    mem_drain();
    lat = 2;
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic oe_all, oe_any;
    half = 6; log_q.delete();
    spi_begin();
    spi_bits(8'h03, 8, rx, oe_all, oe_any);
    spi_bits(8'h01, 8, rx, oe_all, oe_any);
    spi_bits(8'h20, 4, rx, oe_all, oe_any);
    spi_end();
    checks++; if (m_oe !== 1'b0)      begin errors++; $display("FAIL abort_oe: got %b exp 0", m_oe); end
    checks++; if (m_valid !== 1'b0)   begin errors++; $display("FAIL abort_mem_valid: got %b exp 0", m_valid); end
    checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL abort_no_mem: got %0d requests exp 0", log_q.size()); end
    test_rdid("abort_rdid", 3);
  endtask

  task automatic test_ignore();
    logic [7:0] rx;
    logic oe_all, oe_any, oe_seen;
    half = 6; log_q.delete();
    spi_begin();
    spi_bits(8'h05, 8, rx, oe_all, oe_any); oe_seen = oe_any;
    for (int i = 0; i < 2; i++) begin
      spi_bits(8'h00, 8, rx, oe_all, oe_any); oe_seen |= oe_any;
      checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL ign_miso%0d: got %h exp ff", i, rx); end
    end
    spi_end();
    checks++; if (oe_seen !== 1'b0)   begin errors++; $display("FAIL ign_oe: got %b exp 0", oe_seen); end
    checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL ign_no_mem: got %0d requests exp 0", log_q.size()); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rx;
    logic oe_all, oe_any;
    half = 6; lat = 2;
    spi_begin();
    spi_bits(8'h03, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    spi_bits(8'h20, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    checks++; if (rx !== 8'h7A) begin errors++; $display("FAIL mid_byte0: got %h exp 7a", rx); end
    spi_bits(8'h00, 4, rx, oe_all, oe_any);
    reset = 1'b1;
    wait_clk(1);
    checks++; if (m_miso !== 1'b1)  begin errors++; $display("FAIL mid_rst_miso: got %b exp 1", m_miso); end
    checks++; if (m_oe !== 1'b0)    begin errors++; $display("FAIL mid_rst_oe: got %b exp 0", m_oe); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_mem_valid: got %b exp 0", m_valid); end
    checks++; if (m_addr !== 24'h0) begin errors++; $display("FAIL mid_rst_mem_addr: got %h exp 000000", m_addr); end
    checks++; if (m_busy !== 1'b0)  begin errors++; $display("FAIL mid_rst_busy: got %b exp 0", m_busy); end
    checks++; if (m_ur !== 1'b0)    begin errors++; $display("FAIL mid_rst_underrun: got %b exp 0", m_ur); end
    wait_clk(2);
    reset = 1'b0;
    wait_clk(10);
    checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL post_rst_busy: got %b exp 1", m_busy); end
    spi_bits(8'h9F, 8, rx, oe_all, oe_any);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    checks++; if (oe_any !== 1'b0) begin errors++; $display("FAIL post_rst_no_start_oe: got %b exp 0", oe_any); end
    checks++; if (rx !== 8'hFF)    begin errors++; $display("FAIL post_rst_no_start_miso: got %h exp ff", rx); end
    spi_end();
    mem_drain();
    test_rdid("post_rst_rdid", 3);
  endtask

  initial begin
    test_reset();
    test_read();
    test_rdid("rdid", 5);
    test_addr_mask();
    test_underrun();
    test_abort();
    test_ignore();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
